// File: rtl/cnn_axi_pkg.sv
// Shared types and constants for the CNN AXI burst master.
// Holds the FSM state encoding and AXI field constants.
package cnn_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] SIZE_16B      = 3'b100;
  localparam int unsigned BOUNDARY_4K  = 4096;

  // True when a burst of 'bytes' starting at page offset 'lo'
  // runs past the end of its 4 KB page.
  function automatic logic crosses_4k(
    input logic [11:0] lo,
    input logic [12:0] bytes
  );
    logic [13:0] sum;
    sum = {2'b00, lo} + {1'b0, bytes};
    return (sum > 14'(BOUNDARY_4K));
  endfunction

endpackage

// File: rtl/cnn_axi_burst_master_buf.sv
// Beat buffer: one burst of AXI data beats.
// Synchronous write port, combinational read port.
module cnn_beat_buffer #(
  parameter int DEPTH = 16,
  parameter int DW    = 128,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Capture one read beat per accepted R handshake.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cnn_axi_burst_master.sv
// AXI4 burst mover: reads one burst into a local buffer,
// then writes it back out to the destination address.
module cnn_axi_burst_master
  import cnn_axi_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 12,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int BURST_LEN          = 16,
  parameter int ID_VALUE           = 0
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   input_Addr_Offset,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   output_Addr_Offset,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LAST_BEAT = PW'(BURST_LEN - 1);
  localparam logic [12:0] BURST_BYTES =
    13'(BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));

  state_e state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic error_q, error_d;
  logic arvalid_q, arvalid_d;

  logic r_hs, w_hs;
  logic bad_in, bad_out;
  logic [C_M_AXI_DATA_WIDTH-1:0] buf_rdata;
  logic unused_ids;

  assign unused_ids = ^{M_AXI_RID, M_AXI_BID};

  assign bad_in  = crosses_4k(in_addr_q[11:0], BURST_BYTES)
                 | (in_addr_q[3:0] != 4'd0);
  assign bad_out = crosses_4k(out_addr_q[11:0], BURST_BYTES)
                 | (out_addr_q[3:0] != 4'd0);

  assign M_AXI_RREADY  = (state_q == RD_DATA);
  assign M_AXI_AWVALID = (state_q == WR_ADDR);
  assign M_AXI_WVALID  = (state_q == WR_DATA);
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign TXN_DONE      = (state_q == DONE);
  assign M_AXI_ARVALID = arvalid_q;
  assign ERROR         = error_q;

  assign r_hs = M_AXI_RREADY & M_AXI_RVALID;
  assign w_hs = M_AXI_WVALID & M_AXI_WREADY;

  assign M_AXI_ARID    = C_M_AXI_ID_WIDTH'(ID_VALUE);
  assign M_AXI_ARADDR  = in_addr_q;
  assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_ARSIZE  = SIZE_16B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_DEFAULT;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'd0;

  assign M_AXI_AWID    = C_M_AXI_ID_WIDTH'(ID_VALUE);
  assign M_AXI_AWADDR  = out_addr_q;
  assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_AWSIZE  = SIZE_16B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_DEFAULT;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'd0;

  assign M_AXI_WDATA = buf_rdata;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WLAST = (state_q == WR_DATA) && (rd_ptr_q == LAST_BEAT);

  cnn_beat_buffer #(
    .DEPTH (BURST_LEN),
    .DW    (C_M_AXI_DATA_WIDTH),
    .AW    (AW)
  ) u_buf (
    .clk_i   (M_AXI_ACLK),
    .we_i    (r_hs),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (M_AXI_RDATA),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  // Sequence control: next state, latched addresses, pointers, error.
  always_comb begin
    state_d    = state_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    error_d    = error_q;
    arvalid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (INIT_AXI_TXN) begin
          state_d    = CHECK;
          in_addr_d  = input_Addr_Offset;
          out_addr_d = output_Addr_Offset;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          error_d    = 1'b0;
        end
      end
      CHECK: begin
        if (bad_in || bad_out) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid_d = 1'b1;
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (M_AXI_RRESP != RESP_OKAY) error_d = 1'b1;
          if (wr_ptr_q == LAST_BEAT) begin
            if (!M_AXI_RLAST) error_d = 1'b1;
            state_d = WR_ADDR;
          end else if (M_AXI_RLAST) begin
            error_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (M_AXI_AWREADY) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (w_hs) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == LAST_BEAT) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= IDLE;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
      arvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
      arvalid_q  <= arvalid_d;
    end
  end

endmodule

// File: tb/tb_cnn_axi_burst_master.sv
// Bench for cnn_axi_burst_master: AXI slave model with
// R-to-W scoreboard and scenario tasks.
module tb_cnn_axi_burst_master;

  localparam int BL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic [63:0] in_off = '0;
  logic [63:0] out_off = '0;
  logic txn_done, err;
  logic [11:0] arid, awid, rid, bid;
  logic [63:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arlock, awlock;
  logic [3:0] arcache, awcache, arqos, awqos;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready;
  logic bvalid, bready;
  logic [127:0] rdata, wdata;
  logic [15:0] wstrb;

  int checks = 0;
  int errors = 0;

  int bp = 0;
  bit rand_data = 1'b0;
  int err_beat = -1;
  logic [1:0] bresp_cfg = 2'b00;
  logic [63:0] exp_in, exp_out;
  logic [127:0] sb[$];

  int r_rem = 0, r_idx = 0, w_idx = 0;
  bit r_hs = 0, b_hs = 0, b_pend = 0, aw_ok = 0, w_stall = 0;
  logic [127:0] w_hold_d;
  logic w_hold_l;
  int ar_count = 0, aw_count = 0, done_count = 0;
  int arv_cycles = 0, awv_cycles = 0, w_total = 0;

  always #5 clk = ~clk;

  cnn_axi_burst_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .INIT_AXI_TXN(init),
    .input_Addr_Offset(in_off), .output_Addr_Offset(out_off),
    .TXN_DONE(txn_done), .ERROR(err),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready)
  );

  function automatic logic coin();
    return (bp == 0) || ($urandom_range(0, 2) != 0);
  endfunction

  // Slave model: decisions made at negedge, handshakes land at posedge.
  task automatic slave_model();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0;
        wready = 0; bvalid = 0;
        r_rem = 0; r_idx = 0; w_idx = 0; b_pend = 0; aw_ok = 0;
        r_hs = 0; b_hs = 0; w_stall = 0;
        sb.delete();
        continue;
      end
      if (arvalid) arv_cycles++;
      if (awvalid) awv_cycles++;
      if (txn_done) done_count++;
      if (r_hs) rvalid = 0;
      if (b_hs) bvalid = 0;
      if (!bvalid && b_pend && coin()) begin
        bvalid = 1; bresp = bresp_cfg; b_pend = 0;
      end
      if (!rvalid && r_rem > 0 && coin()) begin
        rvalid = 1;
        rdata = rand_data ? {$urandom, $urandom, $urandom, $urandom}
                          : 128'(r_idx);
        rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
        rlast = (r_rem == 1);
      end
      arready = coin();
      awready = coin();
      wready = coin();
      r_hs = rvalid && rready;
      if (r_hs) begin
        sb.push_back(rdata); r_idx++; r_rem--;
      end
      b_hs = bvalid && bready;
      if (arvalid && arready) begin
        checks++;
        if ({araddr, arlen, arsize, arburst, arid} !==
            {exp_in, 8'd15, 3'b100, 2'b01, 12'd0}) begin
          errors++;
          $display("FAIL ar_fields: got %h/%h expected %h/0f",
                   araddr, arlen, exp_in);
        end
        ar_count++; r_rem = BL; r_idx = 0;
      end
      if (w_stall) begin
        checks++;
        if (!(wvalid && wdata === w_hold_d && wlast === w_hold_l)) begin
          errors++;
          $display("FAIL w_stable: got %h/%b expected %h/%b",
                   wdata, wlast, w_hold_d, w_hold_l);
        end
      end
      if (wvalid) begin
        checks++;
        if (!aw_ok) begin
          errors++;
          $display("FAIL w_before_aw: got wvalid=1 expected 0");
        end
      end
      if (wvalid && wready) begin
        logic [127:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (wdata !== e || wlast !== (w_idx == BL - 1) ||
            wstrb !== 16'hFFFF) begin
          errors++;
          $display("FAIL w_beat%0d: got %h last=%b expected %h last=%b",
                   w_idx, wdata, wlast, e, (w_idx == BL - 1));
        end
        if (w_idx == BL - 1) begin
          b_pend = 1; aw_ok = 0;
        end
        w_idx++; w_total++;
      end
      w_stall = wvalid && !wready;
      w_hold_d = wdata; w_hold_l = wlast;
      if (awvalid && awready) begin
        checks++;
        if ({awaddr, awlen, awsize, awburst, awid} !==
            {exp_out, 8'd15, 3'b100, 2'b01, 12'd0}) begin
          errors++;
          $display("FAIL aw_fields: got %h/%h expected %h/0f",
                   awaddr, awlen, exp_out);
        end
        aw_count++; aw_ok = 1; w_idx = 0;
      end
    end
  endtask

  task automatic pulse_start(input logic [63:0] ia, input logic [63:0] oa);
    @(negedge clk);
    init = 1; in_off = ia; out_off = oa; exp_in = ia; exp_out = oa;
    @(negedge clk);
    init = 0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (!txn_done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checks++;
    if (!txn_done) begin
      errors++;
      $display("FAIL done_timeout: got no TXN_DONE expected within %0d", max);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, txn_done, err, wlast}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {arvalid, awvalid, wvalid, rready, bready, txn_done, err, wlast});
    end
    checks++;
    if ({araddr, awaddr} !== 128'd0) begin
      errors++;
      $display("FAIL reset_addr: got %h %h expected 0", araddr, awaddr);
    end
    checks++;
    if ({arlock, awlock, arcache, awcache, arprot, awprot, arqos, awqos}
        !== {1'b0, 1'b0, 4'b0011, 4'b0011, 3'b0, 3'b0, 4'b0, 4'b0}) begin
      errors++;
      $display("FAIL const_fields: got %h expected cache=3",
               {arlock, awlock, arcache, awcache, arprot, awprot, arqos, awqos});
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    int cyc, a0, w0, d0;
    bp = 0; rand_data = 0;
    a0 = aw_count; w0 = w_total; d0 = done_count;
    pulse_start(64'h1000, 64'h2000);
    wait_done(200, cyc);
    checks++;
    if (cyc !== 38) begin
      errors++; $display("FAIL basic_latency: got %0d expected 38", cyc);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL basic_error: got %b expected 0", err);
    end
    @(negedge clk); #1;
    checks++;
    if (txn_done !== 1'b0) begin
      errors++; $display("FAIL done_width: got %b expected 0", txn_done);
    end
    checks++;
    if (aw_count - a0 != 1 || w_total - w0 != BL || sb.size() != 0 ||
        done_count - d0 != 1) begin
      errors++;
      $display("FAIL basic_counts: got aw=%0d w=%0d sb=%0d d=%0d expected 1 16 0 1",
               aw_count - a0, w_total - w0, sb.size(), done_count - d0);
    end
  endtask

  task automatic test_backpressure();
    int cyc, d0, w0;
    bp = 1; rand_data = 1;
    for (int i = 0; i < 3; i++) begin
      d0 = done_count; w0 = w_total;
      pulse_start(64'h3000 + 64'(i) * 64'h1_0000, 64'h5F00);
      wait_done(3000, cyc);
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || done_count - d0 != 1 || w_total - w0 != BL ||
          sb.size() != 0) begin
        errors++;
        $display("FAIL bp_run%0d: got err=%b d=%0d w=%0d sb=%0d expected 0 1 16 0",
                 i, err, done_count - d0, w_total - w0, sb.size());
      end
    end
    bp = 0; rand_data = 0;
  endtask

  task automatic test_4k_cross();
    int cyc, ar0, aw0;
    ar0 = arv_cycles; aw0 = awv_cycles;
    pulse_start(64'h1F80, 64'h2000);
    wait_done(50, cyc);
    checks++;
    if (cyc !== 2 || err !== 1'b1) begin
      errors++;
      $display("FAIL cross_in: got cyc=%0d err=%b expected 2 1", cyc, err);
    end
    pulse_start(64'h1000, 64'h2008);
    wait_done(50, cyc);
    checks++;
    if (cyc !== 2 || err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_out: got cyc=%0d err=%b expected 2 1", cyc, err);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (arv_cycles != ar0 || awv_cycles != aw0) begin
      errors++;
      $display("FAIL cross_bus: got ar=%0d aw=%0d expected 0 0",
               arv_cycles - ar0, awv_cycles - aw0);
    end
  endtask

  task automatic test_rresp_err();
    int cyc, w0, a0;
    err_beat = 5; w0 = w_total; a0 = aw_count;
    pulse_start(64'h8000, 64'h9000);
    wait_done(200, cyc);
    checks++;
    if (err !== 1'b1 || w_total - w0 != BL || aw_count - a0 != 1) begin
      errors++;
      $display("FAIL rresp: got err=%b w=%0d aw=%0d expected 1 16 1",
               err, w_total - w0, aw_count - a0);
    end
    err_beat = -1;
    pulse_start(64'h8000, 64'h9000);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b expected 0", err);
    end
    wait_done(200, cyc);
    checks++;
    if (err !== 1'b0 || cyc !== 38) begin
      errors++;
      $display("FAIL after_err: got err=%b cyc=%0d expected 0 38", err, cyc);
    end
  endtask

  task automatic test_double_start();
    int cyc, a0, w0, d0;
    a0 = ar_count; w0 = aw_count; d0 = done_count;
    pulse_start(64'hA000, 64'hB000);
    repeat (8) @(negedge clk);
    init = 1; in_off = 64'h7000; out_off = 64'h6000;
    @(negedge clk);
    init = 0;
    wait_done(200, cyc);
    repeat (60) @(negedge clk);
    #1;
    checks++;
    if (ar_count - a0 != 1 || aw_count - w0 != 1 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL double_start: got ar=%0d aw=%0d d=%0d expected 1 1 1",
               ar_count - a0, aw_count - w0, done_count - d0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, a0;
    pulse_start(64'hC000, 64'hD000);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (w_idx == 7 && wvalid) break;
    end
    checks++;
    if (!(wvalid && w_idx == 7)) begin
      errors++;
      $display("FAIL mid_reach: got wvalid=%b beat=%0d expected 1 7", wvalid, w_idx);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({wvalid, awvalid, txn_done, arvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 0000",
               {wvalid, awvalid, txn_done, arvalid});
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    a0 = arv_cycles;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (arv_cycles != a0 || txn_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got ar=%0d done=%b expected 0 0",
               arv_cycles - a0, txn_done);
    end
    pulse_start(64'h1000, 64'h2000);
    wait_done(200, cyc);
    checks++;
    if (cyc !== 38 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_txn: got cyc=%0d err=%b expected 38 0", cyc, err);
    end
  endtask

  initial begin
    rid = '0; bid = '0; rdata = '0; rresp = '0; bresp = '0;
    arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
    exp_in = '0; exp_out = '0;
    fork
      slave_model();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_4k_cross();
    test_rresp_err();
    test_double_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
